xor_accum_nbit: RTL and testbench

XOR_ACCUM_NBIT -- requirements
Module: xor_accum_nbit

---
 rtl/xor_accum_pkg.sv | 13 +
 rtl/xor_gate.sv | 11 +
 rtl/xor_gate_nbit.sv | 19 +
 rtl/xor_accum_nbit.sv | 125 ++++++++++++
 tb/tb_xor_accum_nbit.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/xor_accum_pkg.sv
// Shared types and defaults for the XOR frame accumulator.
// State encoding plus default data and beat-counter widths.
package xor_accum_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/xor_gate.sv
// Single-bit XOR primitive.
// Leaf cell that the wide fold is built from.
module xor_gate (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = a ^ b;

endmodule

// File: rtl/xor_gate_nbit.sv
// WIDTH-bit combinational XOR.
// One xor_gate per bit lane.
module xor_gate_nbit #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      xor_gate u_xor (
         .a (a[i]),
         .b (b[i]),
         .y (y[i])
      );
   end

endmodule

// File: rtl/xor_accum_nbit.sv
// Frame XOR accumulator with a saturating beat counter.
// Define XOR_ACCUM_PARITY_EN to add the registered outParity output.
module xor_accum_nbit
   import xor_accum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] inData,
   input  logic             inLast,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] outY,
   output logic [CNT_W-1:0] outBeats
`ifdef XOR_ACCUM_PARITY_EN
   ,
   output logic             outParity
`endif
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [CNT_W-1:0]   beats_q, beats_d;
   logic [WIDTH-1:0]   base_acc;
   logic [CNT_W-1:0]   base_cnt;
   logic [WIDTH-1:0]   fold;
   logic [CNT_W-1:0]   cnt_inc;
   logic               accept;

   assign inReady  = (state_q == ACCUM) ? 1'b1 : outReady;
   assign outValid = (state_q == DONE);
   assign accept   = inValid & inReady;

   // A beat taken during the DONE handshake starts from a clean frame.
   assign base_acc = (state_q == DONE) ? '0 : acc_q;
   assign base_cnt = (state_q == DONE) ? '0 : cnt_q;
   assign cnt_inc  = (&base_cnt) ? base_cnt : base_cnt + 1'b1;

   xor_gate_nbit #(
      .WIDTH (WIDTH)
   ) u_fold (
      .a (base_acc),
      .b (inData),
      .y (fold)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      beats_d = beats_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               if (inLast) begin
                  y_d     = fold;
                  beats_d = cnt_inc;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  acc_d = fold;
                  cnt_d = cnt_inc;
               end
            end
         end
         DONE: begin
            if (outReady) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACCUM;
               if (accept) begin
                  if (inLast) begin
                     y_d     = fold;
                     beats_d = cnt_inc;
                     state_d = DONE;
                  end else begin
                     acc_d = fold;
                     cnt_d = cnt_inc;
                  end
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         beats_q <= beats_d;
      end
   end

   assign outY     = y_q;
   assign outBeats = beats_q;

`ifdef XOR_ACCUM_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_q <= 1'b0;
      else     parity_q <= ^y_d;
   end

   assign outParity = parity_q;
`endif

endmodule

// File: tb/tb_xor_accum_nbit.sv
// Directed bench for xor_accum_nbit (CNT_W=8 and CNT_W=2 instances).
// Both instances share stimulus; results compared to hand values.
module tb_xor_accum_nbit;

   logic       clk = 1'b0;
   logic       rst;
   logic       inValid;
   logic [7:0] inData;
   logic       inLast;
   logic       outReady;

   logic       inReady, outValid;
   logic [7:0] outY, outBeats;
   logic       inReady2, outValid2;
   logic [7:0] outY2;
   logic [1:0] outBeats2;
`ifdef XOR_ACCUM_PARITY_EN
   logic       outParity, outParity2;
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xor_accum_nbit #(.WIDTH(8), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady),
      .inData   (inData),
      .inLast   (inLast),
      .outValid (outValid),
      .outReady (outReady),
      .outY     (outY),
      .outBeats (outBeats)
`ifdef XOR_ACCUM_PARITY_EN
      ,
      .outParity (outParity)
`endif
   );

   xor_accum_nbit #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady2),
      .inData   (inData),
      .inLast   (inLast),
      .outValid (outValid2),
      .outReady (outReady),
      .outY     (outY2),
      .outBeats (outBeats2)
`ifdef XOR_ACCUM_PARITY_EN
      ,
      .outParity (outParity2)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d,
                        input logic l, input logic r);
      @(negedge clk);
      inValid  = v;
      inData   = d;
      inLast   = l;
      outReady = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      inValid = 1'b0;
      inData = 8'h00;
      inLast = 1'b0;
      outReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", outValid, 0);
      chk("rst_y", outY, 0);
      chk("rst_beats", outBeats, 0);
      chk("rst_ready", inReady, 1);
`ifdef XOR_ACCUM_PARITY_EN
      chk("rst_par", outParity, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // three-beat frame
      drive(1, 8'h0F, 0, 1);
      chk("f3_novalid", outValid, 0);
      drive(1, 8'hF0, 0, 1);
      drive(1, 8'h3C, 1, 1);
      chk("f3_valid", outValid, 1);
      chk("f3_y", outY, 8'hC3);
      chk("f3_beats", outBeats, 3);
`ifdef XOR_ACCUM_PARITY_EN
      chk("f3_par", outParity, 0);
`endif
      drive(0, 8'h00, 0, 1);
      chk("f3_pulse", outValid, 0);

      // stalled result, extra beats ignored
      drive(1, 8'hA5, 1, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'hFF, 1, 0);
         chk("stall_valid", outValid, 1);
         chk("stall_y", outY, 8'hA5);
         chk("stall_beats", outBeats, 1);
         chk("stall_ready", inReady, 0);
      end
      drive(0, 8'h00, 0, 1);
      chk("stall_done", outValid, 0);

      // back-to-back single-beat frames
      drive(1, 8'h01, 1, 1);
      chk("b2b_y1", outY, 8'h01);
      chk("b2b_n1", outBeats, 1);
      @(negedge clk);
      inValid  = 1'b1;
      inData   = 8'h02;
      inLast   = 1'b1;
      outReady = 1'b1;
      #1;
      chk("b2b_ready", inReady, 1);
      @(posedge clk);
      #1;
      chk("b2b_valid2", outValid, 1);
      chk("b2b_y2", outY, 8'h02);
      chk("b2b_n2", outBeats, 1);
      drive(0, 8'h00, 0, 1);
      chk("b2b_end", outValid, 0);

      // six beats: saturates on the CNT_W=2 instance
      for (int i = 0; i < 6; i++)
         drive(1, 8'h11, (i == 5), 1);
      chk("sat_y8", outY, 8'h00);
      chk("sat_n8", outBeats, 6);
      chk("sat_y2", outY2, 8'h00);
      chk("sat_n2", outBeats2, 3);
      chk("sat_v2", outValid2, 1);
      drive(0, 8'h00, 0, 1);

      // idle cycles mid-frame hold state
      drive(1, 8'h10, 0, 1);
      drive(0, 8'hFF, 1, 1);
      drive(0, 8'hFF, 1, 1);
      chk("idle_novalid", outValid, 0);
      drive(1, 8'h01, 1, 1);
      chk("idle_y", outY, 8'h11);
      chk("idle_n", outBeats, 2);
      drive(0, 8'h00, 0, 1);

      // parity of 0xC1
      drive(1, 8'hC1, 1, 1);
      chk("c1_y", outY, 8'hC1);
`ifdef XOR_ACCUM_PARITY_EN
      chk("c1_par", outParity, 1);
`endif
      drive(0, 8'h00, 0, 1);

      // reset mid-frame
      drive(1, 8'h55, 0, 1);
      drive(1, 8'hAA, 0, 1);
      @(negedge clk);
      inValid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_valid", outValid, 0);
      chk("mrst_y", outY, 0);
      chk("mrst_beats", outBeats, 0);
      @(negedge clk);
      rst      = 1'b0;
      inValid  = 1'b1;
      inData   = 8'h07;
      inLast   = 1'b1;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_v2", outValid, 1);
      chk("mrst_y2", outY, 8'h07);
      chk("mrst_n2", outBeats, 1);
      drive(0, 8'h00, 0, 1);
      chk("mrst_end", outValid, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
